// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counting timer: register offsets,
// CTRL field layout, mode codes and controller state encoding.
package timer_counter_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;
    localparam int CTRL_BITS     = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_AUTO    = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

    // Field order mirrors the bit positions above (IM at bit 3, EN at bit 0).
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{im: 1'b0, mode: 2'b00, en: 1'b0};

    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        return {28'd0, c};
    endfunction

    function automatic ctrl_t word_to_ctrl(input logic [31:0] w);
        return ctrl_t'(w[CTRL_BITS-1:0]);
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer with one-shot and auto-reload modes,
// level interrupt request and a combinational read mux on the register offset.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int CNT_WIDTH = 32
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    tc_state_e            r_state;
    ctrl_t                r_ctrl;
    logic [CNT_WIDTH-1:0] r_preset;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_irq_flag;

    tc_state_e            w_state_nxt;
    ctrl_t                w_ctrl_nxt;
    logic [CNT_WIDTH-1:0] w_preset_nxt;
    logic [CNT_WIDTH-1:0] w_count_nxt;
    logic                 w_flag_nxt;
    logic                 w_en_fsm;
    logic                 w_flag_fsm;

    logic [1:0]           w_offset;
    logic                 w_ctrl_we;
    logic                 w_preset_we;
    logic                 w_unused_addr;

    assign w_offset      = Addr[1:0];
    assign w_ctrl_we     = WE & (w_offset == OFF_CTRL);
    assign w_preset_we   = WE & (w_offset == OFF_PRESET);
    assign w_unused_addr = ^Addr[29:2];

    // Controller next-state: reload, count down, raise and retire the interrupt flag
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_en_fsm    = r_ctrl.en;
        w_flag_fsm  = r_irq_flag;
        case (r_state)
            ST_IDLE: begin
                if (r_ctrl.en) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_count_nxt = r_preset;
                w_flag_fsm  = 1'b0;
                w_state_nxt = ST_CNT;
            end
            ST_CNT: begin
                if (!r_ctrl.en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count > CNT_ONE) begin
                    w_count_nxt = r_count - CNT_ONE;
                end else begin
                    // A preset of 0 expires after a single counting cycle, like 1.
                    w_count_nxt = CNT_ZERO;
                    w_flag_fsm  = 1'b1;
                    w_state_nxt = ST_INT;
                end
            end
            ST_INT: begin
                if (r_ctrl.mode == MODE_AUTO) begin
                    w_flag_fsm = 1'b0;
                end else begin
                    w_en_fsm = 1'b0;
                end
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus writes override the controller's own CTRL/flag updates in the same edge
    always_comb begin
        w_ctrl_nxt = r_ctrl;
        w_flag_nxt = w_flag_fsm;
        if (w_ctrl_we) begin
            w_ctrl_nxt = word_to_ctrl(Din);
            w_flag_nxt = 1'b0;
        end else begin
            w_ctrl_nxt.en = w_en_fsm;
            w_flag_nxt    = w_flag_fsm;
        end
    end

    // PRESET only changes on a bus write; LOAD in the same edge sees the old value
    always_comb begin
        w_preset_nxt = r_preset;
        if (w_preset_we) begin
            w_preset_nxt = CNT_WIDTH'(Din);
        end else begin
            w_preset_nxt = r_preset;
        end
    end

    // State and register update with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ctrl     <= CTRL_RESET;
            r_preset   <= CNT_ZERO;
            r_count    <= CNT_ZERO;
            r_irq_flag <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ctrl     <= w_ctrl_nxt;
            r_preset   <= w_preset_nxt;
            r_count    <= w_count_nxt;
            r_irq_flag <= w_flag_nxt;
        end
    end

    // Zero-latency read mux on the register offset
    always_comb begin
        Dout = 32'd0;
        case (w_offset)
            OFF_CTRL:   Dout = ctrl_to_word(r_ctrl);
            OFF_PRESET: Dout = 32'(r_preset);
            OFF_COUNT:  Dout = 32'(r_count);
            default:    Dout = 32'd0;
        endcase
    end

    assign IRQ = r_ctrl.im & r_irq_flag;

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped 32-bit down-counting timer that sits directly downstream of the system bridge.
- Consumes the bridge's word address, write strobe and write data, returns a read word, and raises an interrupt request into the CPU's hardware-interrupt vector.
- Two instances occupy the timer windows (base 0x7f00 and 0x7f10); the bridge performs window selection, this block decodes only the register offset.

Parameters:
- CNT_WIDTH, 32, width of PRESET and COUNT registers (spec values below assume 32).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- Addr  input  30  word address (byte address bits 31:2); only Addr[1:0] (byte bits 3:2) decoded
- WE  input  1  write strobe from bridge, already window-qualified
- Din  input  32  write data
- Dout  output  32  read data, combinational from Addr
- IRQ  output  1  interrupt request, level

Behaviour:
- Registers, by Addr[1:0]:
  - 0 CTRL: bit0 EN, bits2:1 MODE, bit3 IM; bits31:4 read 0, writes ignored.
  - 1 PRESET: read/write.
  - 2 COUNT: read-only, writes ignored.
  - 3 reserved: reads 0, writes ignored.
- Reset (async, immediate): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0. Dout follows Addr; IRQ=0.
- IRQ = IM & irq_flag (combinational from registers).
- Dout: mux on Addr[1:0], zero latency, reflects register values after the most recent edge.
- FSM states, 2-bit encoding IDLE=0, LOAD=1, CNT=2, INT=3:
  - IDLE: EN=1 -> LOAD; else stay.
  - LOAD: COUNT<=PRESET, irq_flag<=0 -> CNT.
  - CNT: EN=0 -> IDLE, COUNT held. Else if COUNT>1: COUNT<=COUNT-1. Else (COUNT 0 or 1): COUNT<=0, irq_flag<=1 -> INT.
  - INT, MODE=0: EN<=0, irq_flag kept -> IDLE. Interrupt holds until software clears it.
  - INT, MODE=1: irq_flag<=0 (one-cycle pulse), EN kept -> IDLE, then auto-reload.
  - MODE=2/3: behave as MODE=0.
- Any CTRL write clears irq_flag in the same edge.
- Timing, CTRL write (EN=1) at edge E0, PRESET=N≥1:
  - LOAD at E1; COUNT=N and CNT at E2.
  - COUNT reaches 0 and irq_flag=1 at E2+N.
  - MODE=1: reload period is N+3 cycles, irq_flag high exactly one cycle per period.
- Simultaneous events:
  - Bus write to CTRL wins over the FSM's EN clear in INT.
  - PRESET write mid-count does not disturb COUNT; it takes effect at the next LOAD.
  - Write to PRESET in the same edge as LOAD: the old PRESET is loaded.
- Clearing EN mid-count: COUNT frozen, state IDLE next edge. Re-enabling reloads from PRESET; there is no resume.
- Reset asserted mid-count: all state clears immediately, independent of clk.

Decomposition:
- Shared package holds:
  - register offsets CTRL=2'd0, PRESET=2'd1, COUNT=2'd2
  - CTRL bit positions (EN, MODE LSB/MSB, IM)
  - MODE constants ONESHOT=0, AUTO=1
  - FSM state typedef/encodings
- Bridge reuses the package offsets.
- Single module; no sub-module is natural (register file and FSM are tightly coupled).

Test Plan:
- Reset mid-count: PRESET=100, EN=1, run 20 cycles, pulse reset between edges -> COUNT=0, IRQ=0, CTRL reads 0 immediately.
- One-shot: PRESET=5, CTRL=0x9 at E0 -> COUNT=5 at E2, 0 at E7, IRQ=1 from E7 and held; EN reads 0 from E8. CTRL write 0x8 -> IRQ=0 next edge.
- Auto-reload: PRESET=3, CTRL=0xB -> IRQ high one cycle every 6 cycles, for 4 periods; CTRL keeps EN=1.
- Masking: CTRL=0x1 (IM=0), PRESET=2 -> IRQ never asserts, COUNT reaches 0. Read Addr=3 -> 0. Write to COUNT ignored.
- Pause/preset-change: PRESET=10, enable, clear EN at COUNT=6 -> COUNT stays 6. Write PRESET=4 and re-enable -> COUNT=4 two edges later.
- PRESET=0 edge case: enable MODE=0 -> IRQ at E3 (one CNT cycle), COUNT=0; write CTRL in the same edge as INT -> written value retained.
